// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM bank: register map addresses and the
// compare-address decode helper.
package pwm_pkg;

    localparam logic [3:0] ADDR_CMP_LAST = 4'h7;
    localparam logic [3:0] ADDR_DIV      = 4'h8;
    localparam logic [3:0] ADDR_TOP      = 4'h9;
    localparam logic [3:0] ADDR_POL      = 4'hA;

    localparam int PWM_W_DEFAULT = 8;

    // Compare slots above the instantiated channel count are silently ignored.
    function automatic logic isCmpAddr(input logic [3:0] addr, input int nCh);
        return (addr <= ADDR_CMP_LAST) && (int'(addr) < nCh);
    endfunction

endpackage

// File: rtl/pwm_bank_if.sv
// Register write port of the PWM bank: a one-cycle strobe carrying the
// address and LSB-aligned data coming from the SPI address decoder.
interface pwm_bank_if;

    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;

    modport master (output wr_en, output wr_addr, output wr_data);
    modport slave  (input  wr_en, input  wr_addr, input  wr_data);

endinterface

// File: rtl/pwm_prescaler.sv
// Clock-enable prescaler: produces one tick every DIV+1 clocks while enabled,
// restarting its count whenever the divisor is rewritten.
module pwm_prescaler
    import pwm_pkg::*;
#(
    parameter int DIV_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             wrEn_i,
    input  logic [3:0]       wrAddr_i,
    input  logic [DIV_W-1:0] wrData_i,
    output logic             tick_o,
    output logic             tickOut_o
);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] preCnt_q;
    logic [DIV_W-1:0] preCnt_d;
    logic             tickOut_q;
    logic             divWr;

    assign divWr  = wrEn_i && (wrAddr_i == ADDR_DIV);
    assign tick_o = ena && (preCnt_q == div_q);

    // The tick of the current clock still counts even if DIV is rewritten now.
    always_comb begin
        preCnt_d = preCnt_q + 1'b1;
        if (!ena || tick_o || divWr) begin
            preCnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q     <= '0;
            preCnt_q  <= '0;
            tickOut_q <= 1'b0;
        end else begin
            preCnt_q  <= preCnt_d;
            tickOut_q <= tick_o;
            if (divWr) begin
                div_q <= wrData_i;
            end
        end
    end

    assign tickOut_o = tickOut_q;

endmodule

// File: rtl/pwm_bank.sv
// N-channel PWM bank with programmable period, double-buffered compare/TOP
// registers that load at period wrap, per-channel polarity and a wrap pulse.
module pwm_bank
    import pwm_pkg::*;
#(
    parameter int N_CH  = 8,
    parameter int PWM_W = PWM_W_DEFAULT,
    parameter int DIV_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ena,
    pwm_bank_if.slave       bus,
    output logic [N_CH-1:0] pwm_out,
    output logic            period_start,
    output logic            tick_out
);

    logic             tick;
    logic             wrap;
    logic             loadAct;
    logic             wrTop;
    logic             wrPol;
    logic [PWM_W-1:0] cnt_q;
    logic [PWM_W-1:0] cnt_d;
    logic [PWM_W-1:0] topSh_q;
    logic [PWM_W-1:0] topSh_d;
    logic [PWM_W-1:0] topAct_q;
    logic [N_CH-1:0]  pol_q;
    logic [N_CH-1:0]  pwm_q;
    logic [N_CH-1:0]  pwm_d;
    logic             periodStart_q;
    logic             unusedWrData;

    assign unusedWrData = ^bus.wr_data;

    pwm_prescaler #(
        .DIV_W (DIV_W)
    ) uPrescaler (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .wrEn_i    (bus.wr_en),
        .wrAddr_i  (bus.wr_addr),
        .wrData_i  (bus.wr_data[DIV_W-1:0]),
        .tick_o    (tick),
        .tickOut_o (tick_out)
    );

    assign wrTop = bus.wr_en && (bus.wr_addr == ADDR_TOP);
    assign wrPol = bus.wr_en && (bus.wr_addr == ADDR_POL);
    assign wrap  = tick && (cnt_q == topAct_q);

    // Actives load from the post-write shadow so a write on the wrap clock
    // lands in the new period; while disabled they simply follow the shadows.
    assign loadAct = wrap || !ena;
    assign topSh_d = wrTop ? bus.wr_data[PWM_W-1:0] : topSh_q;

    always_comb begin
        cnt_d = cnt_q;
        if (!ena || wrap) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : gCh
        logic             wrCmp;
        logic [PWM_W-1:0] cmpSh_q;
        logic [PWM_W-1:0] cmpSh_d;
        logic [PWM_W-1:0] cmpAct_q;

        assign wrCmp   = bus.wr_en && isCmpAddr(bus.wr_addr, N_CH)
                         && (bus.wr_addr[2:0] == 3'(i));
        assign cmpSh_d = wrCmp ? bus.wr_data[PWM_W-1:0] : cmpSh_q;
        assign pwm_d[i] = ena ? ((cnt_q < cmpAct_q) ^ pol_q[i]) : pol_q[i];

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                cmpSh_q  <= '0;
                cmpAct_q <= '0;
            end else begin
                cmpSh_q <= cmpSh_d;
                if (loadAct) begin
                    cmpAct_q <= cmpSh_d;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            topSh_q       <= '1;
            topAct_q      <= '1;
            pol_q         <= '0;
            pwm_q         <= '0;
            periodStart_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            topSh_q       <= topSh_d;
            pwm_q         <= pwm_d;
            periodStart_q <= wrap;
            if (loadAct) begin
                topAct_q <= topSh_d;
            end
            if (wrPol) begin
                pol_q <= bus.wr_data[N_CH-1:0];
            end
        end
    end

    assign pwm_out      = pwm_q;
    assign period_start = periodStart_q;

endmodule

// File: tb/tb_pwm_bank.sv
// Bench for pwm_bank: an 8-channel and a 4-channel instance share one stimulus
// stream and are compared every clock against a behavioural model of the bank.
module tb_pwm_bank;

    logic        clk = 1'b0;
    logic        rstN;
    logic        ena;
    logic        wrEn;
    logic [3:0]  wrAddr;
    logic [15:0] wrData;

    logic [7:0]  pwmOut8;
    logic        ps8;
    logic        tick8;
    logic [3:0]  pwmOut4;
    logic        ps4;
    logic        tick4;

    int total = 0;
    int bad   = 0;

    int mDiv[2];
    int mPre[2];
    int mCnt[2];
    int mTopSh[2];
    int mTopAct[2];
    int mPol[2];
    int mCmpSh[2][8];
    int mCmpAct[2][8];
    int ePwm[2];
    int ePs[2];
    int eTick[2];

    int hiCnt;
    int hi1Cnt;
    int hi2Cnt;
    int psCnt;
    int tickCnt;

    pwm_bank_if bus8 ();
    pwm_bank_if bus4 ();

    pwm_bank #(.N_CH(8), .PWM_W(8), .DIV_W(4)) dut8 (
        .clk          (clk),
        .rst_n        (rstN),
        .ena          (ena),
        .bus          (bus8),
        .pwm_out      (pwmOut8),
        .period_start (ps8),
        .tick_out     (tick8)
    );

    pwm_bank #(.N_CH(4), .PWM_W(8), .DIV_W(4)) dut4 (
        .clk          (clk),
        .rst_n        (rstN),
        .ena          (ena),
        .bus          (bus4),
        .pwm_out      (pwmOut4),
        .period_start (ps4),
        .tick_out     (tick4)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock of the bank as described by its register-level rules.
    task automatic modelStep(input int k, input int nch);
        bit tick;
        bit wrap;
        int nextPre;
        int nextCnt;
        int pwmVal;
        int polBit;
        if (!rstN) begin
            mDiv[k] = 0; mPre[k] = 0; mCnt[k] = 0; mPol[k] = 0;
            mTopSh[k] = 255; mTopAct[k] = 255;
            for (int i = 0; i < 8; i++) begin
                mCmpSh[k][i] = 0;
                mCmpAct[k][i] = 0;
            end
            ePwm[k] = 0; ePs[k] = 0; eTick[k] = 0;
            return;
        end
        tick = ena && (mPre[k] == mDiv[k]);
        wrap = tick && (mCnt[k] == mTopAct[k]);
        pwmVal = 0;
        for (int i = 0; i < nch; i++) begin
            polBit = (mPol[k] >> i) & 1;
            if (ena)
                pwmVal |= (((mCnt[k] < mCmpAct[k][i]) ? 1 : 0) ^ polBit) << i;
            else
                pwmVal |= polBit << i;
        end
        ePwm[k]  = pwmVal;
        ePs[k]   = wrap ? 1 : 0;
        eTick[k] = tick ? 1 : 0;
        nextPre = (!ena || tick) ? 0 : mPre[k] + 1;
        nextCnt = (!ena || wrap) ? 0 : (tick ? mCnt[k] + 1 : mCnt[k]);
        if (wrEn) begin
            if (int'(wrAddr) < nch) mCmpSh[k][int'(wrAddr)] = int'(wrData) & 255;
            else if (wrAddr == 4'h8) begin
                mDiv[k] = int'(wrData) & 15;
                nextPre = 0;
            end
            else if (wrAddr == 4'h9) mTopSh[k] = int'(wrData) & 255;
            else if (wrAddr == 4'hA) mPol[k] = int'(wrData) & ((1 << nch) - 1);
        end
        if (!ena || wrap) begin
            mTopAct[k] = mTopSh[k];
            for (int i = 0; i < 8; i++) mCmpAct[k][i] = mCmpSh[k][i];
        end
        mPre[k] = nextPre;
        mCnt[k] = nextCnt;
    endtask

    task automatic applyStimulus(input bit r, input bit e, input bit w,
                                 input logic [3:0] a, input logic [15:0] d);
        rstN = r; ena = e; wrEn = w; wrAddr = a; wrData = d;
        bus8.wr_en = w; bus8.wr_addr = a; bus8.wr_data = d;
        bus4.wr_en = w; bus4.wr_addr = a; bus4.wr_data = d;
        @(posedge clk);
        modelStep(0, 8);
        modelStep(1, 4);
        #1;
        checkOutput("pwm8",  32'(pwmOut8), 32'(ePwm[0]));
        checkOutput("ps8",   32'(ps8),     32'(ePs[0]));
        checkOutput("tick8", 32'(tick8),   32'(eTick[0]));
        checkOutput("pwm4",  32'(pwmOut4), 32'(ePwm[1]));
        checkOutput("ps4",   32'(ps4),     32'(ePs[1]));
        checkOutput("tick4", 32'(tick4),   32'(eTick[1]));
    endtask

    task automatic tally();
        hiCnt   += int'(pwmOut8[0]);
        hi1Cnt  += int'(pwmOut8[1]);
        hi2Cnt  += int'(pwmOut8[2]);
        psCnt   += int'(ps8);
        tickCnt += int'(tick8);
    endtask

    task automatic clearTally();
        hiCnt = 0; hi1Cnt = 0; hi2Cnt = 0; psCnt = 0; tickCnt = 0;
    endtask

    task automatic idleCount(input int n, input bit e);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, e, 1'b0, 4'h0, 16'h0);
            tally();
        end
    endtask

    task automatic writeCount(input logic [3:0] a, input logic [15:0] d, input bit e);
        applyStimulus(1'b1, e, 1'b1, a, d);
        tally();
    endtask

    task automatic waitPs(input int limit, output int waited);
        waited = 0;
        for (int i = 1; i <= limit; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 4'h0, 16'h0);
            if (ps8 === 1'b1) begin
                waited = i;
                break;
            end
        end
        if (waited == 0) checkOutput("psTimeout", 32'd0, 32'd1);
    endtask

    initial begin
        int waited;
        bit rr;
        bit ee;
        bit ww;
        logic [3:0]  aa;
        logic [15:0] dd;

        // Reset held with writes and enable active.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 4'(i), 16'h55 + 16'(i));
            checkOutput("rstPwm", 32'(pwmOut8), 32'd0);
            checkOutput("rstPs",  32'(ps8),     32'd0);
            checkOutput("rstTick", 32'(tick8),  32'd0);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 16'h0);
            checkOutput("idlePwm", 32'(pwmOut8), 32'd0);
            checkOutput("idlePs",  32'(ps8),     32'd0);
        end

        // Basic duty: 3 of 10 high, one wrap per 10 clocks, tick every clock.
        applyStimulus(1'b1, 1'b0, 1'b1, 4'h8, 16'd0);
        applyStimulus(1'b1, 1'b0, 1'b1, 4'h9, 16'd9);
        applyStimulus(1'b1, 1'b0, 1'b1, 4'h0, 16'd3);
        idleCount(15, 1'b1);
        clearTally();
        idleCount(20, 1'b1);
        checkOutput("dutyHigh", 32'(hiCnt),   32'd6);
        checkOutput("dutyPs",   32'(psCnt),   32'd2);
        checkOutput("dutyTick", 32'(tickCnt), 32'd20);

        // Double buffering: mid-period write waits for the wrap.
        waitPs(20, waited);
        clearTally();
        idleCount(4, 1'b1);
        writeCount(4'h0, 16'd7, 1'b1);
        idleCount(5, 1'b1);
        checkOutput("bufOld", 32'(hiCnt), 32'd3);
        checkOutput("bufWrapPs", 32'(ps8), 32'd1);
        clearTally();
        idleCount(10, 1'b1);
        checkOutput("bufNew", 32'(hiCnt), 32'd7);
        // Write landing on the wrap clock goes straight to the active copy.
        clearTally();
        idleCount(9, 1'b1);
        writeCount(4'h0, 16'd2, 1'b1);
        checkOutput("wrapWrPs", 32'(ps8), 32'd1);
        clearTally();
        idleCount(10, 1'b1);
        checkOutput("wrapWrThrough", 32'(hiCnt), 32'd2);

        // Prescale and compare boundaries.
        applyStimulus(1'b1, 1'b0, 1'b1, 4'h8, 16'd3);
        applyStimulus(1'b1, 1'b0, 1'b1, 4'h9, 16'd4);
        applyStimulus(1'b1, 1'b0, 1'b1, 4'h1, 16'd0);
        applyStimulus(1'b1, 1'b0, 1'b1, 4'h2, 16'd5);
        applyStimulus(1'b1, 1'b0, 1'b1, 4'hA, 16'h0002);
        idleCount(30, 1'b1);
        clearTally();
        idleCount(20, 1'b1);
        checkOutput("preTick", 32'(tickCnt), 32'd5);
        checkOutput("prePs",   32'(psCnt),   32'd1);
        checkOutput("cmpZeroInv", 32'(hi1Cnt), 32'd20);
        checkOutput("cmpAboveTop", 32'(hi2Cnt), 32'd20);

        // Ignored addresses (0xB everywhere, 0x5 on the 4-channel instance).
        applyStimulus(1'b1, 1'b1, 1'b1, 4'hB, 16'hFFFF);
        applyStimulus(1'b1, 1'b1, 1'b1, 4'h5, 16'h0033);
        idleCount(30, 1'b1);

        // Randomized traffic, mostly enabled, occasional reset.
        ee = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            rr = ($urandom_range(0, 499) != 0);
            if ($urandom_range(0, 59) == 0) ee = ~ee;
            ww = ($urandom_range(0, 3) == 0);
            aa = 4'($urandom_range(0, 15));
            dd = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 8));
            applyStimulus(rr, ee, ww, aa, dd);
        end

        // Mid-run reset: outputs clear, TOP returns to 255.
        idleCount(50, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'h0, 16'h0);
        checkOutput("midRstPwm",  32'(pwmOut8), 32'd0);
        checkOutput("midRstPs",   32'(ps8),     32'd0);
        checkOutput("midRstTick", 32'(tick8),   32'd0);
        waitPs(300, waited);
        checkOutput("midRstPeriod", 32'(waited), 32'd256);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
